// File: rtl/scaled_packer.sv
// scaled_packer: converts a wide signed fixed-point sample (7 fractional bits)
// into the 16-bit scaled operand word {mant[12:0], scale[2:0]} used by the
// arithmetic units, where value = mant * 2^-scale.
// The converter starts at the finest scale (7) and shifts the sample right by
// one bit per cycle until the mantissa fits 13 signed bits. If it still does
// not fit at scale 0, the mantissa saturates and out_ovf flags the word.
// There is no rounding: each shift truncates toward -inf, matching the
// datapath truncation behaviour.
module scaled_packer #(
  parameter int IN_W = 24
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [IN_W-1:0] in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [15:0]     out_data,
  output logic            out_ovf
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [2:0] SCALE_MAX = 3'd7;

  logic [1:0]              state;
  logic signed [IN_W-1:0]  acc;
  logic [2:0]              scale;

  // True when the value is in -4096..4095, i.e. bits [IN_W-1:12] are a pure
  // sign extension.
  function automatic logic fits13(input logic signed [IN_W-1:0] a);
    logic [IN_W-13:0] top;
    top = a[IN_W-1:12];
    return (&top) || (~|top);
  endfunction

  // Clamps an out-of-range value to the nearest 13-bit mantissa limit.
  function automatic logic [12:0] sat_mant(input logic signed [IN_W-1:0] a);
    return a[IN_W-1] ? 13'h1000 : 13'h0FFF;
  endfunction

  // New samples are accepted only when no conversion is in flight.
  assign in_ready = (state == IDLE);

  // Conversion FSM: accept, shift until the mantissa fits or saturate, then
  // hold the word until the consumer takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      scale     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            acc     <= signed'(in_data);
            scale   <= SCALE_MAX;
            out_ovf <= 1'b0;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (fits13(acc)) begin
            out_data  <= {acc[12:0], scale};
            out_ovf   <= 1'b0;
            out_valid <= 1'b1;
            state     <= DONE;
          end else if (scale != 3'd0) begin
            acc   <= acc >>> 1;
            scale <= scale - 3'd1;
          end else begin
            out_data  <= {sat_mant(acc), 3'd0};
            out_ovf   <= 1'b1;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_scaled_packer.sv
// Directed testbench for scaled_packer with hand-computed expected words.
module tb_scaled_packer;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_ovf;

  int n_checks = 0;
  int n_fail   = 0;

  scaled_packer #(.IN_W(24)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one sample with out_ready high, measure edges to out_valid,
  // check the packed word and the return to IDLE after the handshake.
  task automatic convert(input string tag, input logic [23:0] d,
                         input logic [15:0] ew, input logic eo, input int elat);
    int n;
    in_data   = d;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk({tag, "_busy"}, {31'd0, in_ready}, 32'd0);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_lat"}, n, elat);
    chk({tag, "_data"}, {16'd0, out_data}, {16'd0, ew});
    chk({tag, "_ovf"}, {31'd0, out_ovf}, {31'd0, eo});
    @(posedge clk); #1;
    chk({tag, "_vld_clr"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_idle"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_data", {16'd0, out_data}, 32'd0);
    chk("rst_ovf", {31'd0, out_ovf}, 32'd0);
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic conversions
    convert("t1000", 24'd1000, 16'h1F47, 1'b0, 1);
    convert("tzero", 24'd0, 16'h0007, 1'b0, 1);
    convert("t20000", 24'd20000, 16'h4E24, 1'b0, 4);
    convert("tm20000", -24'sd20000, 16'hB1E4, 1'b0, 4);

    // Boundaries
    convert("tm4096", -24'sd4096, 16'h8007, 1'b0, 1);
    convert("t4095", 24'd4095, 16'h7FFF, 1'b0, 1);
    convert("t4096", 24'd4096, 16'h4006, 1'b0, 2);
    convert("t4097", 24'd4097, 16'h4006, 1'b0, 2);
    convert("tm4097", -24'sd4097, 16'hBFFE, 1'b0, 2);

    // Saturation
    convert("satpos", 24'h7FFFFF, 16'h7FF8, 1'b1, 8);
    convert("satneg", 24'h800000, 16'h8000, 1'b1, 8);

    // Backpressure: hold out_ready low with a second sample waiting
    in_data   = 24'd1000;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_data = 24'd2000;
    @(posedge clk); #1;
    chk("bp_valid_up", {31'd0, out_valid}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk($sformatf("bp_hold_data%0d", i), {16'd0, out_data}, 32'h1F47);
      chk($sformatf("bp_hold_busy%0d", i), {31'd0, in_ready}, 32'd0);
      chk($sformatf("bp_hold_vld%0d", i), {31'd0, out_valid}, 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_hs_vld", {31'd0, out_valid}, 32'd0);
    chk("bp_hs_idle", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_second_acc", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    chk("bp_second_vld", {31'd0, out_valid}, 32'd1);
    chk("bp_second_data", {16'd0, out_data}, 32'h3E87);
    @(posedge clk); #1;
    chk("bp_second_done", {31'd0, in_ready}, 32'd1);

    // Async reset in the middle of a saturating conversion
    in_data  = 24'h7FFFFF;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", {31'd0, out_valid}, 32'd0);
    chk("ar_data", {16'd0, out_data}, 32'd0);
    chk("ar_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    convert("ar_next", -24'sd20000, 16'hB1E4, 1'b0, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=completion");
    $fatal(1, "watchdog expired");
  end

endmodule
